iic_wr_ctrl: RTL
================

// Module: iic_wr_ctrl
// PURPOSE
// - Sequencer directly upstream of the IIC byte transmitter. Takes one write command (chip, reg, data).
// - Runs the phases START -> CHIP -> REG -> DATA -> STOP over one-hot trans_* strobes and finish_* inputs.
// - Drives the byte to shift on data_out. Write only; ack slots are not checked.
// PARAMETERS
// - FIN_MASK_CYC  2     cycles after phase entry during which finish_* are ignored (covers registered finish latency)
// - TIMEOUT_CYC   1023  watchdog limit per phase, in clk cycles (only used with IIC_WR_TIMEOUT_EN)
// PORTS
// - clk           in   1  system clock; single clock domain
// - rst           in   1  asynchronous reset, active-high
// - cmd_valid     in   1  command request
// - cmd_ready     out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
// - cmd_chip      in   7  7-bit slave address
// - cmd_reg       in   8  register address
// - cmd_data      in   8  write data byte
// - busy          out  1  high in every state except IDLE
// - done          out  1  one-cycle pulse when STOP completes normally
// - err           out  1  one-cycle pulse on watchdog abort; tied 0 without the macro
// - trans_start/trans_chip/trans_reg/trans_data/trans_stop  out  1 each  phase strobes; at most one high
// - finish_start/finish_chip/finish_reg/finish_data/finish_stop  in  1 each  phase-complete from the transmitter
// - data_out      out  8  byte for the current phase
// BEHAVIOUR
// - Reset: state=IDLE; all trans_*=0; data_out=8'h00; busy=0; done=0; err=0; cmd_ready=1. No reset-synchroniser inside.
// - All outputs are registered.
// - Capture on accept: chip byte = {cmd_chip,1'b0} (R/W=0); reg and data bytes held in registers until the next accept.
// - Later changes on cmd_* do not affect the transaction in flight.
// - FSM: IDLE -accept-> START -> CHIP -> REG -> DATA -> STOP -> DONE -> IDLE.
//   - Each phase state asserts only its trans_x, from the cycle after entry.
//   - data_out: chip byte in CHIP, cmd_reg in REG, cmd_data in DATA; 8'h00 elsewhere.
// - Phase advance:
//   - Per-phase counter ph_cnt resets to 0 on state entry.
//   - Advance on the first cycle with finish_x==1 (own phase only) and ph_cnt >= FIN_MASK_CYC.
//   - Masked or foreign finish_* are ignored; a stale finish pulse never skips a phase.
//   - trans_x drops and the next trans_y rises on the same clk edge; no gap cycle.
// - DONE: one cycle; done=1, busy=1. Next cycle IDLE with cmd_ready=1.
//   - Fastest back-to-back: a command with cmd_valid held is accepted on the first IDLE cycle.
// - cmd_valid while busy: not accepted, no side effect.
// - Simultaneous events: several finish_* high at once -> only the current phase's finish counts. Reset overrides all.
// - Reset mid-transaction: immediate return to reset values. No STOP is generated; the bus is released by the transmitter's own reset.
// - ph_cnt saturates at TIMEOUT_CYC; width $clog2(TIMEOUT_CYC+1); no wrap.
// CONFIGURATION
// - IIC_WR_TIMEOUT_EN defined:
//   - In START/CHIP/REG/DATA, ph_cnt reaching TIMEOUT_CYC without an accepted finish aborts to STOP.
//   - err pulses for 1 cycle when that STOP completes; done stays 0.
//   - A timeout in STOP itself goes straight to IDLE with an err pulse.
// - IIC_WR_TIMEOUT_EN undefined: no abort. Phases wait forever; err is constant 0; TIMEOUT_CYC only sizes ph_cnt.
// STRUCTURE
// - Package iic_pkg holds:
//   - state enum (IDLE, START, CHIP, REG, DATA, STOP, DONE)
//   - IIC_WR_BIT=1'b0
//   - default FIN_MASK_CYC/TIMEOUT_CYC constants
// - Sub-module iic_wd_timer: phase counter with clear, saturation, mask_done and timeout flags. Shared with future read controller.
// - FSM and capture registers stay in this module.
// TESTING
// - Transmitter model returns finish_x 20 cycles after trans_x rises.
// - T1 cmd 0x50/0x12/0xA5 -> data_out seq 0xA0,0x12,0xA5; strobes in order start,chip,reg,data,stop; one done pulse; busy low after.
// - T2 cmd_valid held with two commands -> second accepted the cycle after done; no trans_* overlap; two done pulses.
// - T3 cmd_valid during DATA -> cmd_ready=0; captured regs unchanged; data_out stays 0xA5.
// - T4 finish_start re-pulsed 1 cycle into CHIP (inside mask) -> FSM stays in CHIP until real finish_chip.
// - T5 rst asserted in REG -> same cycle all trans_*=0, busy=0, cmd_ready=1; next command runs normally.
// - T6 (IIC_WR_TIMEOUT_EN) finish_reg withheld -> after 1023 cycles trans_stop rises; err pulse after finish_stop; done never asserted.

Source files
------------

// File: rtl/iic_pkg.sv
// iic_pkg: shared state encoding and default timing constants for the IIC controllers
package iic_pkg;
  typedef enum logic [2:0] {IDLE, START, CHIP, REG, DATA, STOP, DONE} state_t;
  localparam logic IIC_WR_BIT = 1'b0;
  localparam int FIN_MASK_CYC_DEF = 2;
  localparam int TIMEOUT_CYC_DEF = 1023;
endpackage

// File: rtl/iic_wd_timer.sv
// iic_wd_timer: per-phase cycle counter with clear, saturation, finish-mask and watchdog flags
module iic_wd_timer import iic_pkg::*; #(
  parameter int MASK_CYC = FIN_MASK_CYC_DEF,
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic mask_done,
  output logic timeout
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] ph_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) ph_cnt <= '0;
    else if (clr) ph_cnt <= '0;
    else if (ph_cnt != CW'(LIMIT)) ph_cnt <= ph_cnt + 1'b1;
  assign mask_done = ph_cnt >= CW'(MASK_CYC);
  assign timeout = ph_cnt == CW'(LIMIT);
endmodule

// File: rtl/iic_wr_ctrl.sv
// iic_wr_ctrl: write-command sequencer START->CHIP->REG->DATA->STOP for the IIC byte transmitter
// Define IIC_WR_TIMEOUT_EN to enable the per-phase watchdog abort.
module iic_wr_ctrl import iic_pkg::*; #(
  parameter int FIN_MASK_CYC = FIN_MASK_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_chip,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       trans_start,
  output logic       trans_chip,
  output logic       trans_reg,
  output logic       trans_data,
  output logic       trans_stop,
  input  logic       finish_start,
  input  logic       finish_chip,
  input  logic       finish_reg,
  input  logic       finish_data,
  input  logic       finish_stop,
  output logic [7:0] data_out
);
  state_t state, nxt;
  logic [7:0] chip_q, reg_q, data_q;
  logic fin, mask_done, timeout, accept, done_nxt, err_nxt;
  assign accept = state == IDLE && cmd_valid;
  always_comb fin = state == START ? finish_start :
                    state == CHIP  ? finish_chip  :
                    state == REG   ? finish_reg   :
                    state == DATA  ? finish_data  :
                    state == STOP  ? finish_stop  : 1'b0;
  // clearing on every state change makes ph_cnt read 0 in the first cycle of each phase
  iic_wd_timer #(.MASK_CYC(FIN_MASK_CYC), .LIMIT(TIMEOUT_CYC)) u_wd (
    .clk(clk), .rst(rst), .clr(nxt != state), .mask_done(mask_done), .timeout(timeout)
  );
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = cmd_valid ? START : IDLE;
    else if (state == DONE) nxt = IDLE;
    else if (fin && mask_done) nxt = state == STOP ? DONE : state_t'(state + 3'd1);
`ifdef IIC_WR_TIMEOUT_EN
    else if (timeout) nxt = state == STOP ? IDLE : STOP;
`endif
  end
`ifdef IIC_WR_TIMEOUT_EN
  logic abort_q, to_abort;
  assign to_abort = timeout && !(fin && mask_done) && state inside {START, CHIP, REG, DATA};
  always_ff @(posedge clk or posedge rst)
    if (rst) abort_q <= 1'b0;
    else abort_q <= accept ? 1'b0 : abort_q | to_abort;
  assign done_nxt = nxt == DONE && !abort_q;
  assign err_nxt = (nxt == DONE && abort_q) || (state == STOP && nxt == IDLE);
`else
  logic unused_timeout;
  assign unused_timeout = timeout;
  assign done_nxt = nxt == DONE;
  assign err_nxt = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      chip_q <= '0;
      reg_q <= '0;
      data_q <= '0;
      {trans_start, trans_chip, trans_reg, trans_data, trans_stop} <= '0;
      data_out <= 8'h00;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state <= nxt;
      if (accept) begin
        chip_q <= {cmd_chip, IIC_WR_BIT};
        reg_q <= cmd_reg;
        data_q <= cmd_data;
      end
      trans_start <= nxt == START;
      trans_chip <= nxt == CHIP;
      trans_reg <= nxt == REG;
      trans_data <= nxt == DATA;
      trans_stop <= nxt == STOP;
      data_out <= nxt == CHIP ? chip_q : nxt == REG ? reg_q : nxt == DATA ? data_q : 8'h00;
      busy <= nxt != IDLE;
      cmd_ready <= nxt == IDLE;
      done <= done_nxt;
      err <= err_nxt;
    end
endmodule
